// File: rtl/vector_stream_bridge.sv
// Buffers one VECTOR_SIZE-element frame from an upstream layer and replays it to the next layer.
// Define VECTOR_STREAM_BRIDGE_DBUF_EN for ping-pong banks so filling overlaps transmission.
module vector_stream_bridge #(
    parameter int DATA_LENGTH = 14,
    parameter int VECTOR_SIZE = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [DATA_LENGTH-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [DATA_LENGTH-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy,
    output logic [15:0]                   frame_cnt
);

    localparam int PTR_W = $clog2(VECTOR_SIZE) + 1;
    localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(VECTOR_SIZE - 1);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             in_fire, out_fire;
    logic             wr_last, rd_last;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign wr_last  = (wptr_q == LAST_PTR);
    assign rd_last  = (rptr_q == LAST_PTR);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        frame_cnt_d = frame_cnt_q;
        if (in_fire) begin
            wptr_d = wr_last ? '0 : wptr_q + 1'b1;
        end
        if (out_fire) begin
            rptr_d = rd_last ? '0 : rptr_q + 1'b1;
            if (rd_last) begin
                frame_cnt_d = frame_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;

`ifdef VECTOR_STREAM_BRIDGE_DBUF_EN

    logic signed [DATA_LENGTH-1:0] buf_mem [2][VECTOR_SIZE];
    logic [1:0] full_q, full_d;
    logic       wbank_q, wbank_d;
    logic       rbank_q, rbank_d;

    // Writer and reader always sit on different banks when both complete a frame,
    // so set and clear never collide.
    always_comb begin
        full_d  = full_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        if (in_fire && wr_last) begin
            full_d[wbank_q] = 1'b1;
            wbank_d         = ~wbank_q;
        end
        if (out_fire && rd_last) begin
            full_d[rbank_q] = 1'b0;
            rbank_d         = ~rbank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
        end else begin
            full_q  <= full_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_mem[wbank_q][wptr_q[IDX_W-1:0]] <= in_data;
        end
    end

    assign in_ready  = ~reset & ~full_q[wbank_q];
    assign out_valid = full_q[rbank_q];
    assign out_data  = out_valid ? buf_mem[rbank_q][rptr_q[IDX_W-1:0]] : '0;
    assign out_last  = out_valid & rd_last;
    assign busy      = (|full_q) | (wptr_q != '0);

`else

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } state_t;

    logic signed [DATA_LENGTH-1:0] buf_mem [VECTOR_SIZE];
    state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (state_q == FILL && in_fire && wr_last) begin
            state_d = SEND;
        end else if (state_q == SEND && out_fire && rd_last) begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_mem[wptr_q[IDX_W-1:0]] <= in_data;
        end
    end

    // Handshake flags decode straight from the state flop; in_ready is forced low while in reset.
    assign in_ready  = ~reset & (state_q == FILL);
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? buf_mem[rptr_q[IDX_W-1:0]] : '0;
    assign out_last  = out_valid & rd_last;
    assign busy      = (wptr_q != '0) | (state_q == SEND);

`endif

endmodule

// File: tb/tb_vector_stream_bridge.sv
// Scoreboard bench for vector_stream_bridge: frame-level reference model of the handshake
// flags plus an ordered queue of accepted elements checked against every output transfer.
module tb_vector_stream_bridge;

    localparam int DL = 14;
    localparam int VS = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic signed [DL-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DL-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 out_last;
    logic                 busy;
    logic [15:0]          frame_cnt;

    always #5 clk = ~clk;

    vector_stream_bridge #(.DATA_LENGTH(DL), .VECTOR_SIZE(VS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    int total = 0;
    int bad = 0;

    logic signed [DL-1:0] exp_q[$];
    logic signed [DL-1:0] exp_e;
    int in_cnt = 0;
    int out_cnt = 0;
    int in_fr, out_fr;
    logic prev_stall = 1'b0;
    logic signed [DL-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic after_reset = 1'b0;
    int out_mode = 0;   // 0 driven by main, 1 random, 2 toggle

    logic phase_on = 1'b0;
    int run_valid = 0, max_valid = 0;
    int run_nrdy = 0, max_nrdy = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: the model predicts flags from counts of completed input/output frames.
    always @(negedge clk) begin
        if (reset) begin
            check("in_ready_during_reset", in_ready, 0);
            exp_q.delete();
            in_cnt      = 0;
            out_cnt     = 0;
            prev_stall  = 1'b0;
            after_reset = 1'b1;
        end else begin
            in_fr  = in_cnt / VS;
            out_fr = out_cnt / VS;
            if (after_reset) begin
                check("out_data_after_reset", out_data, 0);
                check("out_last_after_reset", out_last, 0);
                after_reset = 1'b0;
            end
            check("out_valid", out_valid, in_fr > out_fr);
`ifdef VECTOR_STREAM_BRIDGE_DBUF_EN
            check("in_ready", in_ready, (in_fr - out_fr) < 2);
`else
            check("in_ready", in_ready, in_fr == out_fr);
`endif
            check("busy", busy, in_cnt != out_cnt);
            check("frame_cnt", frame_cnt, out_fr % 65536);
            if (prev_stall) begin
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got %0d, expected no element", out_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("out_data", out_data, exp_e);
                    check("out_last", out_last, (out_cnt % VS) == VS - 1);
                end
                $display("out #%0d data=%0d last=%0b frame_cnt=%0d", out_cnt, out_data, out_last, frame_cnt);
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                in_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (phase_on) begin
                run_valid = out_valid ? run_valid + 1 : 0;
                run_nrdy  = in_ready ? 0 : run_nrdy + 1;
                if (run_valid > max_valid) max_valid = run_valid;
                if (run_nrdy > max_nrdy) max_nrdy = run_nrdy;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = ~out_ready;
                default: ;
            endcase
        end
    end

    task automatic push(input logic signed [DL-1:0] d);
        int n = 0;
        bit done = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 300) begin
                    total++;
                    bad++;
                    $display("FAIL push_timeout: got no accept in %0d cycles, expected one", n);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (out_cnt != in_cnt && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_count", out_cnt, in_cnt);
    endtask

    task automatic do_reset(input int cycles);
        idle();
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int sv[8] = '{-8192, 8191, -1, 0, 5, -5, 100, -100};
    int base;

    initial begin
        do_reset(3);

        // basic 1..8 frame
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(DL'(i));
        idle();
        drain();
        check("frame_cnt_first", frame_cnt, 1);

        // signed passthrough
        for (int i = 0; i < 8; i++) push(DL'(sv[i]));
        idle();
        drain();

        // backpressure after 3 reads
        base = out_cnt;
        for (int i = 0; i < 8; i++) push(DL'($urandom));
        idle();
        for (int n = 0; n < 100 && out_cnt < base + 3; n++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // in_valid held with 0x1FFF while the frame is pending
        for (int i = 0; i < 8; i++) push(DL'($urandom));
        in_data   = 14'h1FFF;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(14'h1FFF);
        for (int i = 0; i < 7; i++) push(DL'($urandom));
        idle();
        drain();

        // out_ready toggling every cycle
        out_mode = 2;
        for (int i = 0; i < 8; i++) push(DL'($urandom));
        idle();
        drain();
        out_mode  = 0;
        out_ready = 1'b1;

        // reset after 5 of 8 inputs, then a clean frame
        for (int i = 0; i < 5; i++) push(DL'($urandom));
        do_reset(1);
        for (int i = 10; i <= 17; i++) push(DL'(i));
        idle();
        drain();
        check("frame_cnt_after_reset", frame_cnt, 1);

        // three frames back to back
        do_reset(1);
        out_ready = 1'b1;
        run_valid = 0; max_valid = 0; run_nrdy = 0; max_nrdy = 0;
        phase_on  = 1'b1;
        for (int i = 0; i < 24; i++) push(DL'(i + 20));
        idle();
        drain();
        repeat (3) @(posedge clk);
        #1;
        phase_on = 1'b0;
        check("frame_cnt_stream", frame_cnt, 3);
`ifdef VECTOR_STREAM_BRIDGE_DBUF_EN
        check("stream_valid_run", max_valid, 24);
        check("stream_in_ready_low_run", max_nrdy, 0);
`else
        check("stream_valid_run", max_valid, 8);
        check("stream_in_ready_low_run", max_nrdy, 8);
`endif

        // randomized traffic on both sides
        out_mode = 1;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                push(DL'($urandom));
            end
        end
        idle();
        drain();
        out_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "simulation time limit");
    end

endmodule
